// File: rtl/keycode_pkg.sv
// rtl/keycode_pkg.sv - shared types, key codes and helpers for the keycode event decoder
//
// Purpose: event record, FSM state enum, HID codes of the five game keys and
//          two small helpers used by the decoder.
// Ports:   none (package).
package keycode_pkg;

  typedef struct packed {
    logic [7:0] code;
    logic       press;
  } key_evt_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_NONE  = 8'h00;

  // True when code occupies either slot of a keycode word.
  function automatic logic key_in_word(input logic [7:0] code, input logic [15:0] word);
    return (code == word[7:0]) || (code == word[15:8]);
  endfunction

  // Held bitmap {SPACE, D, S, A, W} for a keycode word.
  function automatic logic [4:0] held_bits(input logic [15:0] word);
    return {key_in_word(KEY_SPACE, word), key_in_word(KEY_D, word),
            key_in_word(KEY_S, word), key_in_word(KEY_A, word),
            key_in_word(KEY_W, word)};
  endfunction

endpackage

// File: rtl/keycode_evt_fifo.sv
// rtl/keycode_evt_fifo.sv - show-ahead FIFO of key events with exact occupancy
//
// Purpose: DEPTH-entry FIFO (DEPTH power of 2, >= 2). head is a register that
//          always shows the oldest entry, and keeps its last value when empty.
// Ports:   clk, rst (async, active-high)
//          push, push_data : write request; accepted if not full or popping
//          pop             : remove head; ignored while empty
//          full, empty     : occupancy flags
//          count           : occupancy 0..DEPTH
//          head            : oldest entry
module keycode_evt_fifo
  import keycode_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  key_evt_t                 push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output key_evt_t                 head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  key_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_n;
  logic [CW-1:0]   count_n;
  logic            do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_n    = do_pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_n;
      count  <= count_n;
      // The new head slot is the one being written only when the FIFO
      // holds exactly the incoming event afterwards.
      if (count_n != '0)
        head <= (do_push && rd_n == wr_ptr) ? push_data : mem[rd_n];
    end
  end

endmodule

// File: rtl/keycode_event_decoder.sv
// rtl/keycode_event_decoder.sv - turns SoC keycode word changes into queued press/release events
//
// Purpose: compares the registered keycode word with the last processed word,
//          emits up to four candidates (two releases, then two presses), one per
//          cycle, into a show-ahead event FIFO, and keeps a held-key bitmap.
// Config:  KEYCODE_DEBOUNCE_EN - act only after the word is stable for
//          STABLE_CYCLES cycles.
// Ports:   clk_50, reset_50 (async, active-high)
//          keycode_in   : two HID slots [7:0], [15:8]; 0x00 = empty
//          evt_ready    : consumer takes head event
//          evt_valid, evt_code, evt_press : head event (press = 1)
//          key_held     : {SPACE, D, S, A, W}
//          fifo_count   : FIFO occupancy
//          overflow, overflow_clr : sticky drop flag and its clear
//          busy         : FSM in EMIT
module keycode_event_decoder
  import keycode_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                   clk_50,
  input  logic                   reset_50,
  input  logic [15:0]            keycode_in,
  input  logic                   evt_ready,
  output logic                   evt_valid,
  output logic [7:0]             evt_code,
  output logic                   evt_press,
  output logic [4:0]             key_held,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic                   busy
);

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic [15:0] kc_q, cur, cur_n, prev, prev_n;
  logic [4:0]  held_n;
  logic        push, pop, drop, stable, fifo_full, fifo_empty;
  key_evt_t    push_evt, head;

`ifdef KEYCODE_DEBOUNCE_EN
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  logic [SW-1:0] stable_cnt;

  // Counts cycles since kc_q last changed, saturating at STABLE_CYCLES.
  always_ff @(posedge clk_50 or posedge reset_50) begin
    if (reset_50)
      stable_cnt <= '0;
    else if (keycode_in != kc_q)
      stable_cnt <= '0;
    else if (stable_cnt != SW'(STABLE_CYCLES))
      stable_cnt <= stable_cnt + 1'b1;
  end

  assign stable = (stable_cnt == SW'(STABLE_CYCLES));
`else
  // Keeps STABLE_CYCLES referenced when the debounce counter is compiled out.
  logic unused_stable_cycles;
  assign unused_stable_cycles = ^STABLE_CYCLES;
  assign stable = 1'b1;
`endif

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cur_n    = cur;
    prev_n   = prev;
    held_n   = key_held;
    push     = 1'b0;
    push_evt = '0;
    case (state)
      IDLE: begin
        if (kc_q != prev && stable) begin
          cur_n   = kc_q;
          idx_n   = 2'd0;
          state_n = EMIT;
        end
      end
      EMIT: begin
        case (idx)
          2'd0: begin
            push_evt.code = prev[7:0];
            push = (prev[7:0] != KEY_NONE) && !key_in_word(prev[7:0], cur);
          end
          2'd1: begin
            push_evt.code = prev[15:8];
            push = (prev[15:8] != KEY_NONE) && (prev[15:8] != prev[7:0]) &&
                   !key_in_word(prev[15:8], cur);
          end
          2'd2: begin
            push_evt.code  = cur[7:0];
            push_evt.press = 1'b1;
            push = (cur[7:0] != KEY_NONE) && !key_in_word(cur[7:0], prev);
          end
          default: begin
            push_evt.code  = cur[15:8];
            push_evt.press = 1'b1;
            push = (cur[15:8] != KEY_NONE) && (cur[15:8] != cur[7:0]) &&
                   !key_in_word(cur[15:8], prev);
          end
        endcase
        if (idx == 2'd3) begin
          prev_n  = cur;
          held_n  = held_bits(cur);
          state_n = IDLE;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset_50) begin
    if (reset_50) begin
      kc_q     <= '0;
      state    <= IDLE;
      idx      <= '0;
      cur      <= '0;
      prev     <= '0;
      key_held <= '0;
      overflow <= 1'b0;
    end else begin
      kc_q     <= keycode_in;
      state    <= state_n;
      idx      <= idx_n;
      cur      <= cur_n;
      prev     <= prev_n;
      key_held <= held_n;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

  assign busy      = (state == EMIT);
  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready;
  assign drop      = push && fifo_full && !pop;
  assign evt_code  = head.code;
  assign evt_press = head.press;

  keycode_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk_50),
    .rst       (reset_50),
    .push      (push),
    .push_data (push_evt),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

endmodule

// File: doc/keycode_event_decoder.md
Name: keycode_event_decoder

Overview:
- Consumes the 16-bit keycode word exported by the NIOS soft-core SoC: two USB HID key slots, [7:0] and [15:8], with 0x00 meaning an empty slot.
- Converts changes in that word into discrete press/release events and queues them in a show-ahead FIFO for the game logic.
- Maintains a registered held-key bitmap for the five game keys.
- Sits directly downstream of the SoC keycode PIO, in the same clock domain.

Parameters:
- DEPTH, 8: event FIFO depth; power of 2, minimum 2.
- STABLE_CYCLES, 16: cycles keycode_in must hold steady before it is acted on (used only with the optional feature).

Ports:
- clk_50, in, 1: system clock, 50 MHz.
- reset_50, in, 1: asynchronous, active-high reset.
- keycode_in, in, 16: keycode word from the SoC PIO.
- evt_ready, in, 1: consumer accepts the head event.
- evt_valid, out, 1: head event present.
- evt_code, out, 8: HID code of the head event.
- evt_press, out, 1: 1 = press, 0 = release.
- key_held, out, 5: held bits {SPACE, D, S, A, W}, i.e. bit0 = W (0x1A), bit1 = A (0x04), bit2 = S (0x16), bit3 = D (0x07), bit4 = SPACE (0x2C).
- fifo_count, out, $clog2(DEPTH)+1: current FIFO occupancy.
- overflow, out, 1: sticky flag; at least one event was dropped.
- overflow_clr, in, 1: clears overflow.
- busy, out, 1: FSM is not in IDLE.

Behaviour:
- Reset (async, active-high): FSM to IDLE, FIFO emptied, prev snapshot = 0x0000. All outputs 0: evt_valid, evt_code, evt_press, key_held, fifo_count, overflow, busy.
- Input register: keycode_in is registered into kc_q every cycle.
- IDLE:
  - If kc_q != prev: capture cur = kc_q, set idx = 0, go to EMIT; busy = 1 from the next cycle.
  - Otherwise stay in IDLE.
- EMIT: one candidate per cycle, idx 0..3, releases before presses.
  - idx0 (release): prev[7:0] != 0 and prev[7:0] is not in {cur[7:0], cur[15:8]}.
  - idx1 (release): prev[15:8] != 0, prev[15:8] != prev[7:0], and prev[15:8] is not in cur.
  - idx2 (press): cur[7:0] != 0 and cur[7:0] is not in prev.
  - idx3 (press): cur[15:8] != 0, cur[15:8] != cur[7:0], and cur[15:8] is not in prev.
  - A qualifying candidate is pushed into the FIFO at the end of that cycle.
  - After idx3: prev <= cur, key_held recomputed from cur (registered), return to IDLE.
  - A full EMIT pass always takes 4 cycles, whether or not any candidate qualifies.
- Changes during EMIT: keycode_in keeps being registered but is not compared. On return to IDLE the new kc_q is compared against the updated prev, so no state is lost; intermediate words that never coexist with IDLE are collapsed.
- Latency: for the registering edge E, the candidate at index i is written at edge E+2+i. The FIFO is show-ahead, so evt_valid rises in the cycle after the write.
- FIFO:
  - Pop occurs when evt_valid && evt_ready.
  - Push while full with no pop: event dropped, overflow <= 1.
  - Push while full with a simultaneous pop: event accepted, count unchanged.
  - Push and pop while empty: no bypass. The pushed event appears next cycle; the pop is ignored because evt_valid = 0.
  - Read and write pointers wrap modulo DEPTH.
  - fifo_count is exact, in the range 0..DEPTH.
- overflow_clr:
  - Clears overflow next cycle.
  - A drop in the same cycle wins, so overflow stays 1.
- evt_code / evt_press hold the last head value when evt_valid = 0; they are 0 after reset.
- Reset mid-EMIT: pending candidates are discarded. After release, prev = 0, so a key still held produces a fresh press event.

Optional Feature:
- Macro KEYCODE_DEBOUNCE_EN.
- Defined: a stability counter reloads whenever kc_q changes. IDLE acts only after kc_q has been unchanged for STABLE_CYCLES consecutive cycles, which adds STABLE_CYCLES to latency. The counter resets to 0 asynchronously.
- Undefined: no counter; IDLE acts on the first cycle kc_q != prev.

Decomposition:
- Package keycode_pkg holds:
  - typedef key_evt_t {logic [7:0] code; logic press;}
  - FSM state enum {IDLE, EMIT}
  - localparams KEY_W = 8'h1A, KEY_A = 8'h04, KEY_S = 8'h16, KEY_D = 8'h07, KEY_SPACE = 8'h2C, KEY_NONE = 8'h00
- One sub-module: keycode_evt_fifo. It is a parameterised show-ahead FIFO of key_evt_t with push, pop, full, empty and count.

Test Plan:
- Reset: assert reset_50 with keycode_in = 0x1A04 -> all outputs 0. Deassert -> press 0x04 then press 0x1A, key_held = 5'b00011.
- 0x0000 -> 0x0004, evt_ready = 1 -> exactly one event {0x04, press}, evt_valid high one cycle, key_held[1] = 1. 0x0004 -> 0x0000 -> {0x04, release}, key_held = 0.
- 0x041A -> 0x1604 -> events in order {0x1A, release} then {0x16, press}. 0x04 produces no event; key_held = 5'b00110.
- keycode_in = 0x0404 from 0x0000 -> a single {0x04, press}, fifo_count peaks at 1.
- DEPTH = 8, evt_ready = 0, cycle 0x0000 <-> 0x1A04 five times -> first 8 events kept, fifo_count = 8, overflow = 1. Pulse overflow_clr -> overflow = 0. Drain -> 8 events in order.
- Reset asserted during EMIT idx2 -> FIFO empty, busy = 0. Release with keycode_in = 0x0016 -> {0x16, press}. With KEYCODE_DEBOUNCE_EN and STABLE_CYCLES = 16: a 10-cycle glitch to 0x002C produces no event.
